router_out_drain: RTL

//  Downstream consumer of the 1x3 router output side. Watches valid_out0..2 and grants one

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_skid_buf.sv | 32 +++
 rtl/router_out_drain.sv | 137 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared widths, drain FSM states, header field and round-robin helpers
package router_pkg;
    localparam int DW    = 8;
    localparam int LEN_W = 6;
    localparam int NPORT = 3;
    typedef enum logic [2:0] {IDLE, ARB, HDR, PAY, WAIT, DONE} state_t;
    function automatic logic [LEN_W-1:0] hdr_len(input logic [DW-1:0] h);
        return h[7:2];
    endfunction
    function automatic logic [1:0] hdr_addr(input logic [DW-1:0] h);
        return h[1:0];
    endfunction
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'(NPORT - 1)) ? 2'd0 : p + 2'd1;
    endfunction
    function automatic logic [1:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [1:0] q1, q2;
        q1 = rr_next(p);
        q2 = rr_next(q1);
        return v[p] ? p : v[q1] ? q1 : q2;
    endfunction
endpackage

// File: rtl/router_skid_buf.sv
// router_skid_buf: 2-entry FIFO between router reads and the sink, same-cycle push/pop allowed
module router_skid_buf #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic wp, rp;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
    assign dout = mem[rp];
endmodule

// File: rtl/router_out_drain.sv
// router_out_drain: round-robin drain of the 1x3 router outputs into one skid-buffered sink
module router_out_drain
    import router_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_out0,
    input  logic             valid_out1,
    input  logic             valid_out2,
    input  logic [DW-1:0]    data_out0,
    input  logic [DW-1:0]    data_out1,
    input  logic [DW-1:0]    data_out2,
    output logic             read_en0,
    output logic             read_en1,
    output logic             read_en2,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sop,
    output logic             m_eop,
    output logic [1:0]       m_port,
    output logic             done,
    output logic [1:0]       done_port,
    output logic [LEN_W-1:0] done_len,
    output logic             parity_ok,
    output logic             truncated,
    output logic             drain_busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W:0] REM1 = (LEN_W + 1)'(1);
    state_t state;
    logic [1:0] ptr, grant, occ;
    logic [2:0] valid;
    logic [DW-1:0] din, acc;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0] rem;
    logic [TW-1:0] tcnt;
    logic [DW+3:0] buf_out;
    logic rd, rd_q, hdr_sent, trunc, room, tmo, live;

    assign valid = {valid_out2, valid_out1, valid_out0};
    assign din = (grant == 2'd0) ? data_out0 : (grant == 2'd1) ? data_out1 : data_out2;
    // a read issued last cycle still lands in the buffer, so it counts against the 2 slots
    assign room = (occ == 2'd0) || (occ == 2'd1 && !rd_q);
    assign live = (state == HDR) || (state == PAY);
    assign rd = live && valid[grant] && room && ((state == HDR) ? !hdr_sent : rem != '0);
    assign tmo = live && !valid[grant] && tcnt == TW'(TIMEOUT - 1);
    assign read_en0 = rd && grant == 2'd0;
    assign read_en1 = rd && grant == 2'd1;
    assign read_en2 = rd && grant == 2'd2;
    assign drain_busy = state != IDLE;
    assign m_valid = occ != 2'd0;
    assign {m_data, m_sop, m_eop, m_port} = buf_out;

    router_skid_buf #(.W(DW + 4)) u_buf (
        .clk  (clk),
        .rstn (rstn),
        .push (rd_q),
        .din  ({din, state == HDR, state == WAIT && !trunc, grant}),
        .pop  (m_valid && m_ready),
        .dout (buf_out),
        .occ  (occ)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            grant     <= 2'd0;
            rd_q      <= 1'b0;
            hdr_sent  <= 1'b0;
            trunc     <= 1'b0;
            len       <= '0;
            rem       <= '0;
            acc       <= '0;
            tcnt      <= '0;
            done      <= 1'b0;
            done_port <= 2'd0;
            done_len  <= '0;
            parity_ok <= 1'b0;
            truncated <= 1'b0;
        end else begin
            rd_q <= rd;
            done <= 1'b0;
            if (rd) tcnt <= '0;
            else if (live && !valid[grant]) tcnt <= tcnt + TW'(1);
            case (state)
                IDLE: if (|valid) state <= ARB;
                ARB: begin
                    if (|valid) begin
                        grant <= rr_pick(valid, ptr);
                        ptr   <= rr_next(rr_pick(valid, ptr));
                    end
                    hdr_sent <= 1'b0;
                    trunc    <= 1'b0;
                    len      <= '0;
                    tcnt     <= '0;
                    state    <= (|valid) ? HDR : IDLE;
                end
                HDR: begin
                    if (rd) hdr_sent <= 1'b1;
                    if (tmo) begin
                        trunc <= 1'b1;
                        state <= WAIT;
                    end else if (rd_q) begin
                        len   <= hdr_len(din);
                        rem   <= {1'b0, hdr_len(din)} + REM1;
                        acc   <= din;
                        state <= PAY;
                    end
                end
                PAY: begin
                    if (rd_q) acc <= acc ^ din;
                    if (tmo) begin
                        trunc <= 1'b1;
                        state <= WAIT;
                    end else if (rd) begin
                        rem <= rem - REM1;
                        if (rem == REM1) state <= WAIT;
                    end
                end
                WAIT: if (trunc || rd_q) begin
                    done      <= 1'b1;
                    done_port <= grant;
                    done_len  <= len;
                    parity_ok <= !trunc && acc == din;
                    truncated <= trunc;
                    state     <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
